// File: rtl/sad_accumulator.sv
// Streaming SAD front end: per-beat absolute-difference sum (S1), block accumulation (S2),
// and running minimum SAD / candidate index across one full-search window.
module sad_accumulator #(
    parameter int PIX_PER_CYC = 4,
    parameter int CAND_W      = 10
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     search_start_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic                     in_last_i,
    input  logic [8*PIX_PER_CYC-1:0] cur_pix_i,
    input  logic [8*PIX_PER_CYC-1:0] ref_pix_i,
    output logic                     sad_valid_o,
    input  logic                     sad_ready_i,
    output logic [31:0]              sad_value_o,
    output logic [CAND_W-1:0]        sad_idx_o,
    output logic [31:0]              best_sad_o,
    output logic [CAND_W-1:0]        best_idx_o,
    output logic                     best_valid_o
);

    function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    logic              s1_valid_q, s1_valid_d;
    logic              s1_last_q,  s1_last_d;
    logic [31:0]       s1_sum_q,   s1_sum_d;
    logic [31:0]       acc_q,      acc_d;
    logic [CAND_W-1:0] cand_q,     cand_d;
    logic              sad_valid_q, sad_valid_d;
    logic [31:0]       sad_value_q, sad_value_d;
    logic [CAND_W-1:0] sad_idx_q,   sad_idx_d;
    logic [31:0]       best_sad_q,  best_sad_d;
    logic [CAND_W-1:0] best_idx_q,  best_idx_d;
    logic              best_valid_q, best_valid_d;

    logic [31:0] beat_sum;
    logic [31:0] blk_sum;
    logic        stall;
    logic        accept;

    always_comb begin
        beat_sum = '0;
        for (int k = 0; k < PIX_PER_CYC; k++) begin
            beat_sum = beat_sum + 32'(abs_diff(cur_pix_i[8*k +: 8], ref_pix_i[8*k +: 8]));
        end
    end

    assign blk_sum    = acc_q + s1_sum_q;
    assign stall      = sad_valid_q && !sad_ready_i;
    // Combinational rst term keeps in_ready low for the whole reset, including its first cycle.
    assign in_ready_o = !rst_i && !stall && !search_start_i;
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_last_d    = s1_last_q;
        s1_sum_d     = s1_sum_q;
        acc_d        = acc_q;
        cand_d       = cand_q;
        sad_valid_d  = sad_valid_q;
        sad_value_d  = sad_value_q;
        sad_idx_d    = sad_idx_q;
        best_sad_d   = best_sad_q;
        best_idx_d   = best_idx_q;
        best_valid_d = best_valid_q;

        if (search_start_i) begin
            s1_valid_d   = 1'b0;
            s1_last_d    = 1'b0;
            s1_sum_d     = '0;
            acc_d        = '0;
            cand_d       = '0;
            sad_valid_d  = 1'b0;
            best_sad_d   = '1;
            best_idx_d   = '0;
            best_valid_d = 1'b0;
        end else if (!stall) begin
            // Not stalled means any pending result is being consumed this cycle.
            sad_valid_d = 1'b0;
            s1_valid_d  = accept;
            s1_last_d   = in_last_i;
            s1_sum_d    = beat_sum;
            if (s1_valid_q) begin
                if (s1_last_q) begin
                    sad_valid_d  = 1'b1;
                    sad_value_d  = blk_sum;
                    sad_idx_d    = cand_q;
                    acc_d        = '0;
                    cand_d       = cand_q + 1'b1;
                    best_valid_d = 1'b1;
                    if (blk_sum < best_sad_q) begin
                        best_sad_d = blk_sum;
                        best_idx_d = cand_q;
                    end
                end else begin
                    acc_d = blk_sum;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_sum_q     <= '0;
            acc_q        <= '0;
            cand_q       <= '0;
            sad_valid_q  <= 1'b0;
            sad_value_q  <= '0;
            sad_idx_q    <= '0;
            best_sad_q   <= '1;
            best_idx_q   <= '0;
            best_valid_q <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_last_q    <= s1_last_d;
            s1_sum_q     <= s1_sum_d;
            acc_q        <= acc_d;
            cand_q       <= cand_d;
            sad_valid_q  <= sad_valid_d;
            sad_value_q  <= sad_value_d;
            sad_idx_q    <= sad_idx_d;
            best_sad_q   <= best_sad_d;
            best_idx_q   <= best_idx_d;
            best_valid_q <= best_valid_d;
        end
    end

    assign sad_valid_o  = sad_valid_q;
    assign sad_value_o  = sad_value_q;
    assign sad_idx_o    = sad_idx_q;
    assign best_sad_o   = best_sad_q;
    assign best_idx_o   = best_idx_q;
    assign best_valid_o = best_valid_q;

endmodule
